// File: rtl/simple_threshold_notional_gate_if.sv
// Order/decision handshake bundle for simple_threshold_notional_gate.
// The gate is the slave: it consumes notionals and produces decisions.
interface simple_threshold_notional_gate_if #(
    parameter int unsigned PROD_W = 49,
    parameter int unsigned ACC_W  = 52
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PROD_W-1:0]        in_notional;
    logic                     in_side;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_action;
    logic [PROD_W-1:0]        out_notional;
    logic signed [ACC_W-1:0]  out_exposure;

    modport master (
        output in_valid, in_notional, in_side, out_ready,
        input  in_ready, out_valid, out_action, out_notional, out_exposure
    );

    modport slave (
        input  in_valid, in_notional, in_side, out_ready,
        output in_ready, out_valid, out_action, out_notional, out_exposure
    );
endinterface

// File: rtl/simple_threshold_notional_gate.sv
// Classifies notionals against a large-order threshold and a signed net-exposure limit,
// with post-reject cooldown. Define SIMPLE_THRESHOLD_GATE_STATS_EN to add reject_count.
module simple_threshold_notional_gate #(
    parameter int unsigned PROD_W   = 49,
    parameter int unsigned ACC_W    = 52,
    parameter int unsigned COOLDOWN = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [PROD_W-1:0]    cfg_threshold,
    input  logic [ACC_W-2:0]     cfg_limit,
    input  logic                 cfg_clear,
    simple_threshold_notional_gate_if.slave bus,
    output logic [CNT_W-1:0]     trig_count
`ifdef SIMPLE_THRESHOLD_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0]     reject_count
`endif
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_COOL = 1'b1;

    localparam logic [1:0] ACT_SMALL  = 2'b00;
    localparam logic [1:0] ACT_LARGE  = 2'b10;
    localparam logic [1:0] ACT_REJECT = 2'b01;

    localparam int unsigned    CW        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0]  COOL_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    logic [0:0]               r_state;
    logic [CW-1:0]            r_cool_cnt;
    logic signed [ACC_W-1:0]  r_exposure;
    logic                     r_out_valid;
    logic [1:0]               r_out_action;
    logic [PROD_W-1:0]        r_out_notional;
    logic signed [ACC_W-1:0]  r_out_exposure;
    logic [CNT_W-1:0]         r_trig_count;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_large;
    logic signed [ACC_W:0]    w_cur;
    logic signed [ACC_W:0]    w_delta;
    logic signed [ACC_W:0]    w_new;
    logic [ACC_W:0]           w_abs;

    always_comb begin
        w_in_ready = (r_state == ST_RUN) && !cfg_clear && (!r_out_valid || bus.out_ready);
        w_accept   = bus.in_valid && w_in_ready;
        // One extra bit so the signed sum can never wrap before the limit check.
        w_cur      = {r_exposure[ACC_W-1], r_exposure};
        w_delta    = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_notional};
        w_new      = bus.in_side ? (w_cur + w_delta) : (w_cur - w_delta);
        w_abs      = w_new[ACC_W] ? -w_new : w_new;
        w_reject   = w_abs > {2'b00, cfg_limit};
        w_large    = bus.in_notional >= cfg_threshold;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_out_valid    <= 1'b0;
            r_out_action   <= ACT_SMALL;
            r_out_notional <= '0;
            r_out_exposure <= '0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_notional <= bus.in_notional;
            if (w_reject) begin
                r_out_action   <= ACT_REJECT;
                r_out_exposure <= r_exposure;
            end else begin
                r_out_action   <= w_large ? ACT_LARGE : ACT_SMALL;
                r_out_exposure <= w_new[ACC_W-1:0];
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_exposure   <= '0;
            r_trig_count <= '0;
        end else if (cfg_clear) begin
            r_exposure   <= '0;
            r_trig_count <= '0;
        end else if (w_accept && !w_reject) begin
            r_exposure <= w_new[ACC_W-1:0];
            if (w_large && !(&r_trig_count)) begin
                r_trig_count <= r_trig_count + CNT_W'(1);
            end
        end
    end

    // Cooldown keeps counting even while a decision is held by backpressure.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= ST_RUN;
            r_cool_cnt <= '0;
        end else if (cfg_clear) begin
            r_state    <= ST_RUN;
            r_cool_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && w_reject && (COOLDOWN > 0)) begin
                        r_state    <= ST_COOL;
                        r_cool_cnt <= COOL_LOAD;
                    end
                end
                default: begin
                    if (r_cool_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

`ifdef SIMPLE_THRESHOLD_GATE_STATS_EN
    logic [CNT_W-1:0] r_reject_count;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_reject_count <= '0;
        end else if (cfg_clear) begin
            r_reject_count <= '0;
        end else if (w_accept && w_reject && !(&r_reject_count)) begin
            r_reject_count <= r_reject_count + CNT_W'(1);
        end
    end

    assign reject_count = r_reject_count;
`endif

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_action   = r_out_action;
    assign bus.out_notional = r_out_notional;
    assign bus.out_exposure = r_out_exposure;
    assign trig_count       = r_trig_count;

endmodule
